video_pattern_gen: RTL and testbench

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_pattern_gen_if.sv | 29 ++
 rtl/video_pattern_gen.sv | 136 +++++++++++++
 tb/tb_video_pattern_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/video_pattern_gen_if.sv
// Video timing/pattern bundle between a raster timing source and video_pattern_gen.
// master drives timing and pattern request; slave (the generator) returns pixels and delayed syncs.
interface video_pattern_gen_if #(
    parameter int COORDSPC = 16
) ();
    logic                       video_enable;
    logic                       hsync;
    logic                       vsync;
    logic                       frame_start;
    logic                       line_start;
    logic signed [COORDSPC-1:0] sx;
    logic signed [COORDSPC-1:0] sy;
    logic [1:0]                 pattern_sel;
    logic [23:0]                rgb_out;
    logic                       de_out;
    logic                       hsync_out;
    logic                       vsync_out;
    logic [1:0]                 pattern_cur;

    modport master (
        output video_enable, hsync, vsync, frame_start, line_start, sx, sy, pattern_sel,
        input  rgb_out, de_out, hsync_out, vsync_out, pattern_cur
    );

    modport slave (
        input  video_enable, hsync, vsync, frame_start, line_start, sx, sy, pattern_sel,
        output rgb_out, de_out, hsync_out, vsync_out, pattern_cur
    );
endinterface

// File: rtl/video_pattern_gen.sv
// Two-stage test-pattern generator: colour bars, checkerboard, gradient, moving bar.
// Define VIDEO_PATTERN_AUTOCYCLE_EN to cycle patterns every AUTO_FRAMES frames instead of using pattern_sel.
module video_pattern_gen #(
    parameter int HRES        = 640,
    parameter int VRES        = 480,
    parameter int COORDSPC    = 16,
    parameter int CHK_LOG2    = 5,
    parameter int BAR_W       = 32,
    parameter int AUTO_FRAMES = 120,
    parameter int H_POL       = 0,
    parameter int V_POL       = 0
) (
    input  logic               video_clk_pix,
    input  logic               rst_pix,
    video_pattern_gen_if.slave vid
);
    localparam int   BAR_PIX = HRES / 8;
    localparam int   COLW    = (BAR_PIX > 2) ? $clog2(BAR_PIX) : 1;
    localparam int   CW      = (COORDSPC > 12) ? COORDSPC + 1 : 13;
    localparam logic HS_IDLE = (H_POL == 0) ? 1'b1 : 1'b0;
    localparam logic VS_IDLE = (V_POL == 0) ? 1'b1 : 1'b0;

    if ((HRES % 8) != 0 || VRES < 1 || AUTO_FRAMES < 1 || CHK_LOG2 >= COORDSPC) begin : g_bad_params
        $error("video_pattern_gen: invalid parameter set");
    end

    logic [COLW-1:0] col_q, col_d;
    logic [2:0]      bar_q, bar_d;
    logic [1:0]      pattern_q, pattern_d, pattern_eff;
    logic [10:0]     offset_q, offset_d, offset_eff;
    logic [23:0]     rgb1_q, rgb1_d, rgb2_q;
    logic            de1_q, de2_q, hs1_q, hs2_q, vs1_q, vs2_q;
    logic [CW-1:0]   sx_w, bar_lo, bar_hi;
    logic            bar_hit;

`ifdef VIDEO_PATTERN_AUTOCYCLE_EN
    localparam int FCW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    always_ff @(posedge video_clk_pix) begin
        if (rst_pix) fcnt_q <= '0;
        else         fcnt_q <= fcnt_d;
    end
`endif

    always_comb begin
        pattern_d = pattern_q;
        offset_d  = offset_q;
`ifdef VIDEO_PATTERN_AUTOCYCLE_EN
        fcnt_d    = fcnt_q;
`endif
        if (vid.frame_start) begin
            offset_d = (offset_q == 11'(HRES - 1)) ? '0 : offset_q + 11'd1;
`ifdef VIDEO_PATTERN_AUTOCYCLE_EN
            if (fcnt_q == FCW'(AUTO_FRAMES - 1)) begin
                fcnt_d    = '0;
                pattern_d = pattern_q + 2'd1;
            end else begin
                fcnt_d    = fcnt_q + FCW'(1);
            end
`else
            pattern_d = vid.pattern_sel;
`endif
        end
    end

    // The frame_start pixel itself already uses the new pattern/offset, so no frame mixes two.
    assign pattern_eff = vid.frame_start ? pattern_d : pattern_q;
    assign offset_eff  = vid.frame_start ? offset_d  : offset_q;

    // Bar index tracks sx incrementally: col counts pixels within a bar, bar counts bars.
    always_comb begin
        if (vid.sx == '0) begin
            col_d = '0;
            bar_d = '0;
        end else if (col_q == COLW'(BAR_PIX - 1)) begin
            col_d = '0;
            bar_d = bar_q + 3'd1;
        end else begin
            col_d = col_q + COLW'(1);
            bar_d = bar_q;
        end
    end

    assign sx_w    = CW'($unsigned(vid.sx));
    assign bar_lo  = CW'(offset_eff);
    assign bar_hi  = bar_lo + CW'(BAR_W);
    assign bar_hit = !vid.sx[COORDSPC-1] && (sx_w >= bar_lo) && (sx_w < bar_hi);

    always_comb begin
        rgb1_d = '0;
        case (pattern_eff)
            // white, yellow, cyan, green, magenta, red, blue, black
            2'd0: rgb1_d = {{8{~bar_d[1]}}, {8{~bar_d[2]}}, {8{~bar_d[0]}}};
            2'd1: rgb1_d = (vid.sx[CHK_LOG2] ^ vid.sy[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            2'd2: rgb1_d = {3{vid.sx[7:0]}};
            default: rgb1_d = bar_hit ? 24'hFFFFFF : 24'h0000FF;
        endcase
    end

    always_ff @(posedge video_clk_pix) begin
        if (rst_pix) begin
            col_q     <= '0;
            bar_q     <= '0;
            pattern_q <= '0;
            offset_q  <= '0;
            rgb1_q    <= '0;
            rgb2_q    <= '0;
            de1_q     <= 1'b0;
            de2_q     <= 1'b0;
            hs1_q     <= HS_IDLE;
            hs2_q     <= HS_IDLE;
            vs1_q     <= VS_IDLE;
            vs2_q     <= VS_IDLE;
        end else begin
            col_q     <= col_d;
            bar_q     <= bar_d;
            pattern_q <= pattern_d;
            offset_q  <= offset_d;
            rgb1_q    <= rgb1_d;
            de1_q     <= vid.video_enable;
            hs1_q     <= vid.hsync;
            vs1_q     <= vid.vsync;
            rgb2_q    <= de1_q ? rgb1_q : '0;
            de2_q     <= de1_q;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
        end
    end

    assign vid.rgb_out     = rgb2_q;
    assign vid.de_out      = de2_q;
    assign vid.hsync_out   = hs2_q;
    assign vid.vsync_out   = vs2_q;
    assign vid.pattern_cur = pattern_q;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen; with VIDEO_PATTERN_AUTOCYCLE_EN defined it checks auto-cycling instead.
module tb_video_pattern_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] hpat;

    always #5 clk = ~clk;

    video_pattern_gen_if #(.COORDSPC(16)) vif ();

    video_pattern_gen #(
        .HRES(640), .VRES(480), .COORDSPC(16), .CHK_LOG2(5), .BAR_W(32),
        .AUTO_FRAMES(4), .H_POL(0), .V_POL(0)
    ) dut (
        .video_clk_pix(clk),
        .rst_pix      (rst),
        .vid          (vif)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
        end
    endtask

    // Output after each drive reflects the inputs of the previous drive (two register stages).
    task automatic drive(input logic en, input logic hs, input logic vs, input logic fs,
                         input logic ls, input int x, input int y);
        vif.video_enable = en;
        vif.hsync        = hs;
        vif.vsync        = vs;
        vif.frame_start  = fs;
        vif.line_start   = ls;
        vif.sx           = 16'(x);
        vif.sy           = 16'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [23:0] exp);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, x, y);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        chk(tag, vif.rgb_out, exp);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        vif.pattern_sel = 2'd3;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("rst_rgb", vif.rgb_out, 24'h000000);
        chk("rst_de", {23'd0, vif.de_out}, 24'd0);
        chk("rst_hs", {23'd0, vif.hsync_out}, 24'd1);
        chk("rst_vs", {23'd0, vif.vsync_out}, 24'd1);
        chk("rst_pat", {22'd0, vif.pattern_cur}, 24'd0);
        rst = 1'b0;

`ifdef VIDEO_PATTERN_AUTOCYCLE_EN
        for (int k = 1; k <= 17; k++) begin
            vif.pattern_sel = 2'(k);
            frames(1);
            chk($sformatf("auto_pat_%0d", k), {22'd0, vif.pattern_cur}, 24'((k / 4) % 4));
        end
`else
        vif.pattern_sel = 2'd0;
        for (int i = 0; i <= 641; i++) begin
            drive(i < 640, 1'b1, 1'b1, 1'b0, 1'b0, i, 0);
            if (i == 0)   chk("bars_pre_de", {23'd0, vif.de_out}, 24'd0);
            if (i == 1)   chk("bars_sx0", vif.rgb_out, 24'hFFFFFF);
            if (i == 1)   chk("bars_sx0_de", {23'd0, vif.de_out}, 24'd1);
            if (i == 80)  chk("bars_sx79", vif.rgb_out, 24'hFFFFFF);
            if (i == 81)  chk("bars_sx80", vif.rgb_out, 24'hFFFF00);
            if (i == 161) chk("bars_sx160", vif.rgb_out, 24'h00FFFF);
            if (i == 321) chk("bars_sx320", vif.rgb_out, 24'hFF00FF);
            if (i == 560) chk("bars_sx559", vif.rgb_out, 24'h0000FF);
            if (i == 561) chk("bars_sx560", vif.rgb_out, 24'h000000);
            if (i == 561) chk("bars_sx560_de", {23'd0, vif.de_out}, 24'd1);
            if (i == 641) chk("bars_end_de", {23'd0, vif.de_out}, 24'd0);
        end

        hpat = 8'b1011_0010;
        for (int j = 0; j < 8; j++) begin
            drive(1'b0, hpat[j], ~hpat[j], 1'b0, 1'b0, 100, 0);
            if (j > 0) begin
                chk($sformatf("blank_hs_%0d", j), {23'd0, vif.hsync_out}, {23'd0, hpat[j-1]});
                chk($sformatf("blank_vs_%0d", j), {23'd0, vif.vsync_out}, {23'd0, ~hpat[j-1]});
            end
        end
        chk("blank_rgb", vif.rgb_out, 24'h000000);
        chk("blank_de", {23'd0, vif.de_out}, 24'd0);

        vif.pattern_sel = 2'd1;
        for (int x = 5; x < 9; x++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, x, 7);
        chk("midframe_pat", {22'd0, vif.pattern_cur}, 24'd0);
        frames(1);
        chk("switch_pat1", {22'd0, vif.pattern_cur}, 24'd1);
        probe("chk_32_0", 32, 0, 24'hFFFFFF);
        probe("chk_32_32", 32, 32, 24'h000000);
        probe("chk_0_32", 0, 32, 24'hFFFFFF);

        vif.pattern_sel = 2'd2;
        frames(1);
        probe("grad_300", 300, 0, 24'h2C2C2C);
        probe("grad_255", 255, 0, 24'hFFFFFF);

        vif.pattern_sel = 2'd3;
        frames(1);
        chk("switch_pat3", {22'd0, vif.pattern_cur}, 24'd3);
        probe("mbar3_sx2", 2, 0, 24'h0000FF);
        probe("mbar3_sx3", 3, 0, 24'hFFFFFF);
        probe("mbar3_sx34", 34, 0, 24'hFFFFFF);
        probe("mbar3_sx35", 35, 0, 24'h0000FF);
        frames(617);
        probe("mbar620_sx619", 619, 0, 24'h0000FF);
        probe("mbar620_sx620", 620, 0, 24'hFFFFFF);
        probe("mbar620_sx639", 639, 0, 24'hFFFFFF);
        probe("mbar620_sx0", 0, 0, 24'h0000FF);
        frames(19);
        probe("mbar639_sx639", 639, 0, 24'hFFFFFF);
        probe("mbar639_sx638", 638, 0, 24'h0000FF);
        probe("mbar639_sx0", 0, 0, 24'h0000FF);
        frames(1);
        probe("mbarwrap_sx0", 0, 0, 24'hFFFFFF);
        probe("mbarwrap_sx31", 31, 0, 24'hFFFFFF);
        probe("mbarwrap_sx32", 32, 0, 24'h0000FF);

        frames(100);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 100, 5);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 101, 5);
        chk("prerst_rgb", vif.rgb_out, 24'hFFFFFF);
        chk("prerst_hs", {23'd0, vif.hsync_out}, 24'd0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 102, 5);
        chk("midrst_rgb", vif.rgb_out, 24'h000000);
        chk("midrst_de", {23'd0, vif.de_out}, 24'd0);
        chk("midrst_hs", {23'd0, vif.hsync_out}, 24'd1);
        chk("midrst_vs", {23'd0, vif.vsync_out}, 24'd1);
        chk("midrst_pat", {22'd0, vif.pattern_cur}, 24'd0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("postrst_pat", {22'd0, vif.pattern_cur}, 24'd0);
        frames(1);
        chk("postrst_pat3", {22'd0, vif.pattern_cur}, 24'd3);
        probe("postrst_sx0", 0, 0, 24'h0000FF);
        probe("postrst_sx1", 1, 0, 24'hFFFFFF);
        probe("postrst_sx32", 32, 0, 24'hFFFFFF);
        probe("postrst_sx33", 33, 0, 24'h0000FF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
